wb_commit_arb: RTL and testbench
================================

// Module: wb_commit_arb
// PURPOSE
//  Multi-channel writeback/commit stage for the rv32 core. Accepts completed results from
//  NUM_CH execution channels (ALU, LSU, MUL/DIV, ...) over valid/ready and round-robin
//  arbitrates them onto the single register-file write port. Sequences precise traps as
//  an mcause write then an mepc write, and keeps a retired-instruction counter.
//  Sits between the execute/memory units and the register file / CSR file.
// PARAMETERS
//  NUM_CH     3   number of completion channels (>=1)
//  DATA_W     32  datapath / PC width
//  RF_ADDR_W  5   register-file address width
//  CAUSE_W    5   exception cause code width (zero-extended to DATA_W)
//  CNT_W      64  retired-instruction counter width
// PORTS
//  clk_i          in   1                  clock
//  rst_ni         in   1                  reset, asynchronous, active-low
//  ch_valid_i     in   NUM_CH             channel i holds a completed instruction
//  ch_ready_o     out  NUM_CH             channel i accepted this cycle (valid&ready = handshake)
//  ch_rd_we_i     in   NUM_CH             instruction writes rd
//  ch_rd_addr_i   in   NUM_CH*RF_ADDR_W   rd address, channel i at [i*RF_ADDR_W +: RF_ADDR_W]
//  ch_rd_data_i   in   NUM_CH*DATA_W      rd data
//  ch_exc_i       in   NUM_CH             instruction raised an exception
//  ch_cause_i     in   NUM_CH*CAUSE_W     exception cause code
//  ch_pc_i        in   NUM_CH*DATA_W      instruction PC
//  rf_we_o        out  1                  register-file write enable
//  rf_waddr_o     out  RF_ADDR_W          register-file write address
//  rf_wdata_o     out  DATA_W             register-file write data
//  csr_we_o       out  1                  CSR write enable
//  csr_addr_o     out  12                 CSR address (0x342 mcause, 0x341 mepc)
//  csr_wdata_o    out  DATA_W             CSR write data
//  flush_o        out  1                  flush younger pipeline state
//  trap_o         out  1                  one-cycle pulse: redirect fetch to trap vector
//  retire_cnt_o   out  CNT_W              retired (non-excepting) instruction count
// BEHAVIOUR
//  - Reset: every output 0; state IDLE; round-robin pointer rr_q=0; retire_cnt_o=0.
//    The reset takes effect immediately on assertion.
//  - FSM states: IDLE, TRAP_CAUSE, TRAP_EPC.
//    - IDLE->TRAP_CAUSE on accepting an excepting beat.
//    - TRAP_CAUSE->TRAP_EPC unconditionally.
//    - TRAP_EPC->IDLE unconditionally.
//  - Arbitration (IDLE only): grant = first valid channel searching rr_q, rr_q+1, ... (mod NUM_CH).
//    - ch_ready_o[grant]=1, all others 0. ch_ready_o may depend on ch_valid_i combinationally.
//    - Channels must hold valid and payload stable until accepted.
//    - On accept: rr_q <= (grant+1) mod NUM_CH. No valid channel: rr_q holds.
//  - In TRAP_CAUSE and TRAP_EPC, ch_ready_o = 0 for all channels.
//  - Outputs are registered. A beat accepted at edge N is visible in the cycle after edge N (1-cycle latency).
//  - Non-excepting beat:
//    - rf_we_o = rd_we & (rd_addr != 0); x0 is never written. Address and data are registered regardless.
//    - retire_cnt_o increments by 1, including rd_we=0 and x0 writes.
//    - Counter wraps modulo 2^CNT_W.
//  - No accept: rf_we_o = 0; rf_waddr_o and rf_wdata_o hold.
//  - Excepting beat:
//    - No RF write and no retire increment. ch_rd_data_i is ignored.
//    - The beat's cause and PC are captured.
//    - TRAP_CAUSE cycle: csr_we_o=1, csr_addr_o=0x342, csr_wdata_o=zero-extended cause, flush_o=1.
//    - TRAP_EPC cycle: csr_we_o=1, csr_addr_o=0x341, csr_wdata_o=pc, flush_o=1, trap_o=1.
//  - csr_we_o, flush_o and trap_o are 0 in IDLE.
//  - Simultaneous excepting and non-excepting valids: only the granted beat is handled.
//    The others wait and keep their round-robin position.
//  - Reset mid-trap: the sequence aborts and no further CSR writes occur. The captured PC is discarded.
//  - NUM_CH=1: grant is always channel 0.
// TESTING
//  1. ch0 valid, rd_we=1, addr=5, data=0xDEADBEEF
//     -> next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF, retire_cnt_o=1.
//  2. ch1 valid, rd_we=1, addr=0
//     -> rf_we_o stays 0, retire_cnt_o increments by 1.
//  3. All 3 channels valid continuously for 6 cycles from reset
//     -> grants 0,1,2,0,1,2, retire_cnt_o=6, no starvation.
//  4. ch2 exc=1, cause=2, pc=0x80000010
//     -> cycle+1: csr_we_o=1, addr 0x342, wdata 2, flush_o=1.
//     -> cycle+2: addr 0x341, wdata 0x80000010, trap_o=1.
//     -> all ch_ready_o=0 in both cycles, rf_we_o=0, counter unchanged.
//  5. CNT_W=4, 16 non-excepting beats
//     -> retire_cnt_o goes 15 then 0.
//  6. rst_ni low during TRAP_CAUSE
//     -> all outputs 0 immediately, no mepc write after release, first post-reset grant = ch0.

Source files
------------

// File: rtl/wb_commit_arb.sv
// Writeback/commit stage: round-robin arbitrates NUM_CH completion channels onto the
// register-file write port, sequences precise traps (mcause then mepc) and counts retirements.
module wb_commit_arb #(
    parameter int NUM_CH    = 3,
    parameter int DATA_W    = 32,
    parameter int RF_ADDR_W = 5,
    parameter int CAUSE_W   = 5,
    parameter int CNT_W     = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_CH-1:0]           ch_valid_i,
    output logic [NUM_CH-1:0]           ch_ready_o,
    input  logic [NUM_CH-1:0]           ch_rd_we_i,
    input  logic [NUM_CH*RF_ADDR_W-1:0] ch_rd_addr_i,
    input  logic [NUM_CH*DATA_W-1:0]    ch_rd_data_i,
    input  logic [NUM_CH-1:0]           ch_exc_i,
    input  logic [NUM_CH*CAUSE_W-1:0]   ch_cause_i,
    input  logic [NUM_CH*DATA_W-1:0]    ch_pc_i,
    output logic                        rf_we_o,
    output logic [RF_ADDR_W-1:0]        rf_waddr_o,
    output logic [DATA_W-1:0]           rf_wdata_o,
    output logic                        csr_we_o,
    output logic [11:0]                 csr_addr_o,
    output logic [DATA_W-1:0]           csr_wdata_o,
    output logic                        flush_o,
    output logic                        trap_o,
    output logic [CNT_W-1:0]            retire_cnt_o
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_TRAP_CAUSE = 2'd1;
    localparam logic [1:0] ST_TRAP_EPC   = 2'd2;

    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MEPC   = 12'h341;

    logic [1:0]           state_q;
    logic [IDX_W-1:0]     rr_q;
    logic [IDX_W-1:0]     grant;
    logic [IDX_W-1:0]     rr_nxt;
    logic                 any_valid;
    logic                 accept;
    logic [DATA_W-1:0]    epc_p1;

    logic                 g_we;
    logic                 g_exc;
    logic [RF_ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0]    g_data;
    logic [CAUSE_W-1:0]   g_cause;
    logic [DATA_W-1:0]    g_pc;

    // Rotating priority search: the first valid channel at or after rr_q wins.
    always_comb begin
        int idx;
        grant     = rr_q;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!any_valid && ch_valid_i[idx]) begin
                any_valid = 1'b1;
                grant     = IDX_W'(idx);
            end
        end
    end

    assign rr_nxt = (int'(grant) == NUM_CH - 1) ? '0 : grant + IDX_W'(1);
    assign accept = (state_q == ST_IDLE) && any_valid;

    always_comb begin
        ch_ready_o = '0;
        if (accept) ch_ready_o[grant] = 1'b1;
    end

    assign g_we    = ch_rd_we_i[grant];
    assign g_exc   = ch_exc_i[grant];
    assign g_addr  = ch_rd_addr_i[int'(grant)*RF_ADDR_W +: RF_ADDR_W];
    assign g_data  = ch_rd_data_i[int'(grant)*DATA_W +: DATA_W];
    assign g_cause = ch_cause_i[int'(grant)*CAUSE_W +: CAUSE_W];
    assign g_pc    = ch_pc_i[int'(grant)*DATA_W +: DATA_W];

    // Commit stage: accepted beat becomes visible on the outputs one cycle later
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            rr_q         <= '0;
            epc_p1       <= '0;
            rf_we_o      <= 1'b0;
            rf_waddr_o   <= '0;
            rf_wdata_o   <= '0;
            csr_we_o     <= 1'b0;
            csr_addr_o   <= '0;
            csr_wdata_o  <= '0;
            flush_o      <= 1'b0;
            trap_o       <= 1'b0;
            retire_cnt_o <= '0;
        end else begin
            rf_we_o     <= 1'b0;
            csr_we_o    <= 1'b0;
            csr_addr_o  <= '0;
            csr_wdata_o <= '0;
            flush_o     <= 1'b0;
            trap_o      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        rr_q <= rr_nxt;
                        if (g_exc) begin
                            state_q     <= ST_TRAP_CAUSE;
                            epc_p1      <= g_pc;
                            csr_we_o    <= 1'b1;
                            csr_addr_o  <= CSR_MCAUSE;
                            csr_wdata_o <= DATA_W'(g_cause);
                            flush_o     <= 1'b1;
                        end else begin
                            rf_we_o      <= g_we && (g_addr != '0);
                            rf_waddr_o   <= g_addr;
                            rf_wdata_o   <= g_data;
                            retire_cnt_o <= retire_cnt_o + CNT_W'(1);
                        end
                    end
                end
                ST_TRAP_CAUSE: begin
                    state_q     <= ST_TRAP_EPC;
                    csr_we_o    <= 1'b1;
                    csr_addr_o  <= CSR_MEPC;
                    csr_wdata_o <= epc_p1;
                    flush_o     <= 1'b1;
                    trap_o      <= 1'b1;
                end
                ST_TRAP_EPC: state_q <= ST_IDLE;
                default:     state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_commit_arb.sv
// Randomised and directed bench for wb_commit_arb, scored against a behavioural model
// of the commit rules (rotating priority, trap phases, retire count).
module tb_wb_commit_arb;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [2:0]  ch_valid = '0, ch_rd_we = '0, ch_exc = '0;
    logic [14:0] ch_rd_addr = '0, ch_cause = '0;
    logic [95:0] ch_rd_data = '0, ch_pc = '0;

    logic [2:0]  ch_ready;
    logic        rf_we, csr_we, flush, trap;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, csr_wdata;
    logic [11:0] csr_addr;
    logic [63:0] retire_cnt;

    logic [2:0]  ch_ready4;
    logic        rf_we4, csr_we4, flush4, trap4;
    logic [4:0]  rf_waddr4;
    logic [31:0] rf_wdata4, csr_wdata4;
    logic [11:0] csr_addr4;
    logic [3:0]  retire_cnt4;

    always #5 clk_i = ~clk_i;

    wb_commit_arb #(.NUM_CH(3), .DATA_W(32), .RF_ADDR_W(5), .CAUSE_W(5), .CNT_W(64)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .ch_valid_i(ch_valid), .ch_ready_o(ch_ready),
        .ch_rd_we_i(ch_rd_we), .ch_rd_addr_i(ch_rd_addr), .ch_rd_data_i(ch_rd_data),
        .ch_exc_i(ch_exc), .ch_cause_i(ch_cause), .ch_pc_i(ch_pc),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .csr_we_o(csr_we), .csr_addr_o(csr_addr), .csr_wdata_o(csr_wdata),
        .flush_o(flush), .trap_o(trap), .retire_cnt_o(retire_cnt));

    wb_commit_arb #(.NUM_CH(3), .DATA_W(32), .RF_ADDR_W(5), .CAUSE_W(5), .CNT_W(4)) dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .ch_valid_i(ch_valid), .ch_ready_o(ch_ready4),
        .ch_rd_we_i(ch_rd_we), .ch_rd_addr_i(ch_rd_addr), .ch_rd_data_i(ch_rd_data),
        .ch_exc_i(ch_exc), .ch_cause_i(ch_cause), .ch_pc_i(ch_pc),
        .rf_we_o(rf_we4), .rf_waddr_o(rf_waddr4), .rf_wdata_o(rf_wdata4),
        .csr_we_o(csr_we4), .csr_addr_o(csr_addr4), .csr_wdata_o(csr_wdata4),
        .flush_o(flush4), .trap_o(trap4), .retire_cnt_o(retire_cnt4));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          m_ptr;
    int          m_trap_left;   // remaining trap cycles to emit: 2 = mepc next, 1 = idle gap
    logic        e_rf_we, e_csr_we, e_flush, e_trap;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata, e_csr_wdata, m_epc;
    logic [11:0] e_csr_addr;
    logic [63:0] m_cnt;
    int          acc_ch;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic set_ch(input int i, input logic v, input logic we, input logic [4:0] a,
                          input logic [31:0] d, input logic x, input logic [4:0] c,
                          input logic [31:0] pc);
        ch_valid[i] = v;
        ch_rd_we[i] = we;
        ch_exc[i]   = x;
        ch_rd_addr[i*5 +: 5]  = a;
        ch_cause[i*5 +: 5]    = c;
        ch_rd_data[i*32 +: 32] = d;
        ch_pc[i*32 +: 32]      = pc;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_trap_left = 0; m_cnt = '0; m_epc = '0;
        e_rf_we = 0; e_csr_we = 0; e_flush = 0; e_trap = 0;
        e_waddr = '0; e_wdata = '0; e_csr_addr = '0; e_csr_wdata = '0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".rf_we"}, rf_we, e_rf_we);
        check({tag, ".rf_waddr"}, rf_waddr, e_waddr);
        check({tag, ".rf_wdata"}, rf_wdata, e_wdata);
        check({tag, ".cnt"}, retire_cnt, m_cnt);
        check({tag, ".cnt4"}, retire_cnt4, m_cnt[3:0]);
        check({tag, ".csr_we"}, csr_we, e_csr_we);
        if (e_csr_we) begin
            check({tag, ".csr_addr"}, csr_addr, e_csr_addr);
            check({tag, ".csr_wdata"}, csr_wdata, e_csr_wdata);
        end
        check({tag, ".flush"}, flush, e_flush);
        check({tag, ".trap"}, trap, e_trap);
    endtask

    // One clock cycle: predict the grant, check ready, clock, check registered outputs.
    task automatic step(input string tag);
        int g;
        logic [2:0] exp_ready;
        #1;
        g = -1;
        if (m_trap_left == 0)
            for (int k = 0; k < 3; k++)
                if (g < 0 && ch_valid[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
        exp_ready = (g >= 0) ? (3'b001 << g) : 3'b000;
        check({tag, ".ready"}, ch_ready, exp_ready);

        e_rf_we = 0; e_csr_we = 0; e_flush = 0; e_trap = 0;
        if (m_trap_left == 2) begin
            e_csr_we = 1; e_csr_addr = 12'h341; e_csr_wdata = m_epc;
            e_flush = 1; e_trap = 1; m_trap_left = 1;
        end else if (m_trap_left == 1) begin
            m_trap_left = 0;
        end else if (g >= 0) begin
            m_ptr = (g + 1) % 3;
            if (ch_exc[g]) begin
                e_csr_we = 1; e_csr_addr = 12'h342;
                e_csr_wdata = {27'd0, ch_cause[g*5 +: 5]};
                e_flush = 1; m_epc = ch_pc[g*32 +: 32]; m_trap_left = 2;
            end else begin
                e_rf_we = ch_rd_we[g] && (ch_rd_addr[g*5 +: 5] != 5'd0);
                e_waddr = ch_rd_addr[g*5 +: 5];
                e_wdata = ch_rd_data[g*32 +: 32];
                m_cnt   = m_cnt + 64'd1;
            end
        end
        acc_ch = g;
        @(posedge clk_i);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        ch_valid = '0;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        model_reset();
        check_outputs("reset");
        check("reset.ready", ch_ready, 3'b000);
    endtask

    task automatic rand_ch(input int i);
        logic [4:0] a;
        a = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        if ($urandom_range(0, 1) == 1)
            set_ch(i, 1'b1, 1'($urandom), a, $urandom, ($urandom_range(0, 7) == 0),
                   5'($urandom), $urandom);
        else
            ch_valid[i] = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Single beat to x5
        set_ch(0, 1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);
        step("t1");
        check("t1.rf_we_exp", rf_we, 1'b1);
        check("t1.waddr_exp", rf_waddr, 5'd5);
        check("t1.wdata_exp", rf_wdata, 32'hDEADBEEF);
        check("t1.cnt_exp", retire_cnt, 64'd1);
        ch_valid[0] = 0;

        // x0 write is suppressed but still retires
        set_ch(1, 1, 1, 5'd0, 32'h12345678, 0, 5'd0, 32'h0);
        step("t2");
        check("t2.rf_we_exp", rf_we, 1'b0);
        check("t2.cnt_exp", retire_cnt, 64'd2);
        ch_valid[1] = 0;

        // Trap on ch2 while ch0 waits
        set_ch(2, 1, 1, 5'd7, 32'h0, 1, 5'd2, 32'h80000010);
        set_ch(0, 1, 1, 5'd9, 32'hA5A5A5A5, 0, 5'd0, 32'h0);
        step("t4a");
        check("t4a.csr_addr_exp", csr_addr, 12'h342);
        check("t4a.csr_wdata_exp", csr_wdata, 32'd2);
        check("t4a.flush_exp", flush, 1'b1);
        ch_valid[2] = 0;
        step("t4b");
        check("t4b.csr_addr_exp", csr_addr, 12'h341);
        check("t4b.csr_wdata_exp", csr_wdata, 32'h80000010);
        check("t4b.trap_exp", trap, 1'b1);
        check("t4b.cnt_exp", retire_cnt, 64'd2);
        step("t4c");
        step("t4d");
        check("t4d.waiter", rf_waddr, 5'd9);
        ch_valid = '0;

        // All channels valid from reset: strict rotation
        do_reset();
        for (int c = 0; c < 3; c++) set_ch(c, 1, 1, 5'(c + 1), 32'(c), 0, 5'd0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            #1;
            check("t3.grant", ch_ready, 3'b001 << (i % 3));
            step("t3");
        end
        check("t3.cnt_exp", retire_cnt, 64'd6);
        ch_valid = '0;

        // 4-bit counter wrap
        do_reset();
        set_ch(0, 1, 0, 5'd3, 32'h0, 0, 5'd0, 32'h0);
        for (int j = 1; j <= 16; j++) begin
            step("t5");
            if (j == 15) check("t5.cnt4_15", retire_cnt4, 4'd15);
            if (j == 16) check("t5.cnt4_0", retire_cnt4, 4'd0);
        end
        ch_valid = '0;

        // Reset asserted during TRAP_CAUSE
        do_reset();
        set_ch(1, 1, 0, 5'd0, 32'h0, 1, 5'd11, 32'h00001234);
        set_ch(0, 1, 0, 5'd0, 32'h0, 1, 5'd11, 32'h00001234);
        step("t6a");
        ch_valid = '0;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_outputs("t6.async");
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("t6.idle");
            check("t6.no_mepc", csr_we, 1'b0);
        end
        for (int c = 0; c < 3; c++) set_ch(c, 1, 1, 5'd4, 32'h0, 0, 5'd0, 32'h0);
        #1;
        check("t6.first_grant", ch_ready, 3'b001);
        step("t6b");
        ch_valid = '0;

        // Random traffic; a channel keeps its beat until accepted
        do_reset();
        for (int c = 0; c < 3; c++) rand_ch(c);
        for (int n = 0; n < 400; n++) begin
            step("rand");
            if (acc_ch >= 0) ch_valid[acc_ch] = 1'b0;
            for (int c = 0; c < 3; c++)
                if (!ch_valid[c]) rand_ch(c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
